// File: rtl/ram_access_arbiter.sv
// Shares the two 512x50 point RAMs between host single-word accesses and
// core read bursts; splits 91-bit points across the macros and merges reads.
module ram_access_arbiter #(
  parameter int addrWidth    = 9,
  parameter int dataWidth    = 91,
  parameter int ram_word_len = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_active,
  input  logic                    host_req,
  input  logic                    host_we,
  input  logic [addrWidth-1:0]    host_addr,
  input  logic [dataWidth-1:0]    host_wdata,
  output logic                    host_gnt,
  output logic [dataWidth-1:0]    host_rdata,
  output logic                    host_rvalid,
  input  logic                    burst_start,
  input  logic [addrWidth-1:0]    first_addr,
  input  logic [addrWidth-1:0]    last_addr,
  input  logic                    core_hold,
  output logic [dataWidth-1:0]    core_rdata,
  output logic                    core_rvalid,
  output logic                    burst_done,
  output logic                    burst_err,
  output logic [addrWidth-1:0]    ram_addr,
  output logic                    ram_web,
  output logic                    ram_oeb,
  output logic                    ram_csb,
  output logic [ram_word_len-1:0] ram1_din,
  output logic [ram_word_len-1:0] ram2_din,
  input  logic [ram_word_len-1:0] ram1_dout,
  input  logic [ram_word_len-1:0] ram2_dout,
  output logic [1:0]              dbg_state_o
);

  localparam int HiW = dataWidth - ram_word_len;

  typedef enum logic [1:0] {
    HOST_IDLE = 2'd0,
    CORE_IDLE = 2'd1,
    BURST     = 2'd2,
    DRAIN     = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [addrWidth-1:0]    addr_cnt_q, addr_cnt_d;
  logic [addrWidth-1:0]    last_q, last_d;

  logic                    csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
  logic [addrWidth-1:0]    ram_addr_q, ram_addr_d;
  logic [ram_word_len-1:0] din1_q, din1_d, din2_q, din2_d;

  // Read tags: s1 = pins driven toward the RAM, s2 = RAM output valid this cycle.
  logic                    host_s1_q, host_s2_q, core_s1_q, core_s2_q;
  logic                    host_rvalid_q, core_rvalid_q, done_q, err_q;
  logic [dataWidth-1:0]    host_rdata_q, core_rdata_q;

  logic                    host_issue, core_issue, rd_issue, wr_issue;
  logic                    done_d, err_d;
  logic [dataWidth-1:0]    merged;

  assign merged = {ram2_dout[HiW-1:0], ram1_dout};

  // Host handshake: an access is taken at a rising edge where host_req and
  // host_gnt are both high; a read answers with a one-cycle host_rvalid two
  // cycles later. host_req may stay high for back-to-back accesses.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    last_d     = last_q;
    host_gnt   = 1'b0;
    host_issue = 1'b0;
    core_issue = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      HOST_IDLE: begin
        host_gnt   = !core_active && !rst;
        host_issue = host_req && host_gnt;
        if (core_active && !host_s1_q && !host_s2_q) state_d = CORE_IDLE;
      end
      CORE_IDLE: begin
        if (!core_active) begin
          state_d = HOST_IDLE;
        end else if (burst_start) begin
          if (first_addr <= last_addr) begin
            addr_cnt_d = first_addr;
            last_d     = last_addr;
            state_d    = BURST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (!core_hold) begin
          core_issue = 1'b1;
          if (addr_cnt_q == last_q) state_d = DRAIN;
          else addr_cnt_d = addr_cnt_q + {{(addrWidth-1){1'b0}}, 1'b1};
        end
      end
      DRAIN: begin
        // The final read is the only one left once s1 has emptied.
        if (core_s2_q && !core_s1_q) begin
          done_d  = 1'b1;
          state_d = core_active ? CORE_IDLE : HOST_IDLE;
        end
      end
      default: state_d = HOST_IDLE;
    endcase
  end

  always_comb begin
    rd_issue   = (host_issue && !host_we) || core_issue;
    wr_issue   = host_issue && host_we;
    csb_d      = !(rd_issue || wr_issue);
    web_d      = !wr_issue;
    oeb_d      = !rd_issue;
    ram_addr_d = ram_addr_q;
    din1_d     = din1_q;
    din2_d     = din2_q;
    if (host_issue)      ram_addr_d = host_addr;
    else if (core_issue) ram_addr_d = addr_cnt_q;
    if (wr_issue) begin
      din1_d = host_wdata[ram_word_len-1:0];
      din2_d = {{(ram_word_len-HiW){1'b0}}, host_wdata[dataWidth-1:ram_word_len]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HOST_IDLE;
      addr_cnt_q    <= '0;
      last_q        <= '0;
      csb_q         <= 1'b1;
      web_q         <= 1'b1;
      oeb_q         <= 1'b1;
      ram_addr_q    <= '0;
      din1_q        <= '0;
      din2_q        <= '0;
      host_s1_q     <= 1'b0;
      host_s2_q     <= 1'b0;
      core_s1_q     <= 1'b0;
      core_s2_q     <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rvalid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      host_rdata_q  <= '0;
      core_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_cnt_q    <= addr_cnt_d;
      last_q        <= last_d;
      csb_q         <= csb_d;
      web_q         <= web_d;
      oeb_q         <= oeb_d;
      ram_addr_q    <= ram_addr_d;
      din1_q        <= din1_d;
      din2_q        <= din2_d;
      host_s1_q     <= host_issue && !host_we;
      host_s2_q     <= host_s1_q;
      core_s1_q     <= core_issue;
      core_s2_q     <= core_s1_q;
      host_rvalid_q <= host_s2_q;
      core_rvalid_q <= core_s2_q;
      done_q        <= done_d;
      err_q         <= err_d;
      if (host_s2_q) host_rdata_q <= merged;
      if (core_s2_q) core_rdata_q <= merged;
    end
  end

  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign core_rvalid = core_rvalid_q;
  assign burst_done  = done_q;
  assign burst_err   = err_q;
  assign ram_addr    = ram_addr_q;
  assign ram_csb     = csb_q;
  assign ram_web     = web_q;
  assign ram_oeb     = oeb_q;
  assign ram1_din    = din1_q;
  assign ram2_din    = din2_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Owns the two 512x50 single-port point RAMs and shares them between two requesters: the register file, which loads and reads back points over APB, and the k-means controller, which streams points into the classification pipeline. Host accesses are single-word reads and writes. Core accesses are auto-incrementing read bursts over a first..last address window. The block splits each 91-bit point across RAM_1 (low 50 bits) and RAM_2 (high 41 bits), merges read data back into 91 bits, and registers every RAM control pin.

## Interface
Parameters:
- addrWidth, 9, RAM address width.
- dataWidth, 91, point word width.
- ram_word_len, 50, width of each RAM macro.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- core_active  in  1  algorithm running (go); selects core ownership.
- host_req  in  1  host access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  addrWidth  host address.
- host_wdata  in  dataWidth  host write data.
- host_gnt  out  1  host request accepted this cycle.
- host_rdata  out  dataWidth  host read data.
- host_rvalid  out  1  host_rdata valid, one-cycle pulse.
- burst_start  in  1  core burst request pulse.
- first_addr, last_addr  in  addrWidth  inclusive burst window; sampled on burst_start.
- core_hold  in  1  pause burst issue.
- core_rdata  out  dataWidth  burst read data.
- core_rvalid  out  1  core_rdata valid.
- burst_done  out  1  pulse coincident with the last core_rvalid.
- burst_err  out  1  pulse on rejected burst.
- ram_addr  out  addrWidth  shared RAM address.
- ram_web, ram_oeb, ram_csb  out  1 each  active-low RAM controls.
- ram1_din, ram2_din  out  ram_word_len each  RAM write data.
- ram1_dout, ram2_dout  in  ram_word_len each  RAM read data.

## Operation
- State machine with states HOST_IDLE, CORE_IDLE, BURST, DRAIN. Reset state is HOST_IDLE.
- HOST_IDLE:
  - host_gnt = !core_active.
  - A host access is accepted at a clock edge where host_req && host_gnt.
  - Back-to-back host accesses are allowed, one per cycle.
  - Transition to CORE_IDLE when core_active=1 and no host read is in flight.
- CORE_IDLE:
  - host_gnt=0.
  - core_active=0 returns the block to HOST_IDLE.
  - burst_start with first_addr<=last_addr: load addr_cnt=first_addr and last register, go to BURST.
  - burst_start with first_addr>last_addr: pulse burst_err next cycle, perform no RAM access, stay in CORE_IDLE.
- BURST:
  - Each cycle with core_hold=0: issue a read at addr_cnt, then addr_cnt+1.
  - core_hold=1: no issue; csb driven high next cycle; addr_cnt held.
  - Issuing addr_cnt==last goes to DRAIN. first==last gives exactly one read.
  - burst_start is ignored outside CORE_IDLE.
  - A core_active fall during BURST or DRAIN is ignored until the burst completes.
- DRAIN:
  - Wait for the pipeline to empty.
  - burst_done asserts with the final core_rvalid, then go to CORE_IDLE (or HOST_IDLE if core_active=0).
- Write data:
  - ram1_din = wdata[49:0].
  - ram2_din = {9'b0, wdata[90:50]}.
- Read merge:
  - rdata = {ram2_dout[40:0], ram1_dout[49:0]}.
  - ram2_dout[49:41] is ignored.
- Pin encodings:
  - Write: csb=0, web=0, oeb=1.
  - Read: csb=0, web=1, oeb=0.
  - Idle: csb=1, web=1, oeb=1; addr and din hold their last values.
- Address counter never wraps: a burst ends at last ≤ 511.

## Timing
- Reset values:
  - host_gnt=0, host_rvalid=0, core_rvalid=0, burst_done=0, burst_err=0.
  - host_rdata=0, core_rdata=0.
  - ram_addr=0, ram1_din=0, ram2_din=0.
  - ram_csb=1, ram_web=1, ram_oeb=1.
- Reset mid-operation: in-flight reads are discarded, no further rvalid or burst_done pulses, state returns to HOST_IDLE.
- Accept edge E0: RAM pins are registered and driven after E0. The RAM samples at E1. The arbiter registers the merged data at E2. rvalid is high for the cycle after E2.
- Latency from accept edge to rvalid is 2 cycles. Reads are fully pipelined: N unheld burst reads produce N consecutive core_rvalid cycles.
- host_gnt is combinational from state and core_active. In the cycle core_active rises, host_gnt drops immediately.
- burst_err and burst_done are single-cycle pulses.

## Test plan
- Reset check: assert rst for 2 cycles mid-burst -> all outputs at reset values next cycle; no core_rvalid afterwards.
- Host write/read: write addr 1 data 11, then read addr 1 -> pins csb=0/web=0/addr=1 after write accept; host_rvalid 2 cycles after read accept with host_rdata=11.
- Width split: write all-ones to addr 5 -> ram1_din=all ones, ram2_din[40:0] all ones, ram2_din[49:41]=0; readback equals 91'h7FF_FFFF_FFFF_FFFF_FFFF_FFFF.
- Burst: preload addrs 1..8 with 11..18, core_active=1, burst_start first=1 last=8 -> 8 consecutive core_rvalid with data 11..18; burst_done with the 8th; host_gnt=0 throughout.
- Hold and error: core_hold for 3 cycles after the 3rd issue -> 3-cycle gap in core_rvalid, data sequence unbroken; burst_start first=6 last=2 -> burst_err pulse, csb stays 1.
- Ownership change: core_active rises 1 cycle after a host read accept -> host_rvalid still delivered, then state is CORE_IDLE; a host_req during core ownership is never granted.
